// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS word checker with saturating BER statistics
module prbs_checker #(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] POLY         = 8'b00001001,
  parameter int                    LOCK_COUNT   = 4,
  parameter int                    UNLOCK_COUNT = 4,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clear,
  output logic                  locked,
  output logic                  err_flag,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  err_word_count,
  output logic [CNT_WIDTH-1:0]  err_bit_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_MAX   = MW'(LOCK_COUNT);
  localparam logic [UW-1:0] UNLOCK_MAX = UW'(UNLOCK_COUNT);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pred, pred_d;
  logic [MW-1:0]           match_cnt, match_d;
  logic [UW-1:0]           miss_cnt, miss_d;
  logic                    err_d;
  logic [CNT_WIDTH-1:0]    wc_d, ewc_d, ebc_d;
  logic [DATA_WIDTH-1:0]   diff;
  logic [CNT_WIDTH-1:0]    diff_bits;
  logic [CNT_WIDTH:0]      ebc_sum;

  // Fibonacci LFSR step; must match the generator's feedback
  function automatic logic [DATA_WIDTH-1:0] nxt(input logic [DATA_WIDTH-1:0] x);
    return {^(x & POLY), x[DATA_WIDTH-1:1]};
  endfunction

  // Saturating increment so counters stick at all ones instead of wrapping
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Number of mismatching bits in the current word, zero-extended to counter width
  always_comb begin
    diff      = din ^ pred;
    diff_bits = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      diff_bits = diff_bits + CNT_WIDTH'(diff[i]);
    end
    ebc_sum = {1'b0, err_bit_count} + {1'b0, diff_bits};
  end

  // Next-state, predictor and statistics update; idle cycles leave everything as is
  always_comb begin
    state_d = state_q;
    pred_d  = pred;
    match_d = match_cnt;
    miss_d  = miss_cnt;
    err_d   = 1'b0;
    wc_d    = word_count;
    ewc_d   = err_word_count;
    ebc_d   = err_bit_count;
    if (din_valid) begin
      if (state_q == HUNT) begin
        // Resynchronise from received data; zero is the lock-up state and never matches
        pred_d = nxt(din);
        if (din == pred && pred != '0) begin
          match_d = match_cnt + MW'(1);
        end else begin
          match_d = '0;
        end
        if (match_d == LOCK_MAX) begin
          state_d = LOCKED;
          match_d = '0;
          miss_d  = '0;
        end
      end else begin
        // Free-running prediction so line errors cannot corrupt the reference
        pred_d = nxt(pred);
        wc_d   = sat_inc(word_count);
        if (diff != '0) begin
          err_d  = 1'b1;
          ewc_d  = sat_inc(err_word_count);
          ebc_d  = ebc_sum[CNT_WIDTH] ? '1 : ebc_sum[CNT_WIDTH-1:0];
          miss_d = miss_cnt + UW'(1);
        end else begin
          miss_d = '0;
        end
        if (miss_d == UNLOCK_MAX) begin
          state_d = HUNT;
          match_d = '0;
          miss_d  = '0;
          pred_d  = nxt(din);
        end
      end
    end
    if (clear) begin
      wc_d  = '0;
      ewc_d = '0;
      ebc_d = '0;
    end
  end

  // State register and registered outputs with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= HUNT;
      pred           <= '0;
      match_cnt      <= '0;
      miss_cnt       <= '0;
      locked         <= 1'b0;
      err_flag       <= 1'b0;
      word_count     <= '0;
      err_word_count <= '0;
      err_bit_count  <= '0;
    end else begin
      state_q        <= state_d;
      pred           <= pred_d;
      match_cnt      <= match_d;
      miss_cnt       <= miss_d;
      locked         <= (state_d == LOCKED);
      err_flag       <= err_d;
      word_count     <= wc_d;
      err_word_count <= ewc_d;
      err_bit_count  <= ebc_d;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed self-checking bench for prbs_checker
module tb_prbs_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        locked, err_flag;
  logic [31:0] word_count, err_word_count, err_bit_count;

  int errors = 0;
  int checks = 0;
  logic [7:0]  g;
  logic [31:0] exp_wc, exp_ewc, exp_ebc;

  prbs_checker dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clear(clear),
    .locked(locked), .err_flag(err_flag), .word_count(word_count),
    .err_word_count(err_word_count), .err_bit_count(err_bit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {^(x & 8'h09), x[7:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stats(input string tag);
    chk({tag, ".word_count"}, word_count, exp_wc);
    chk({tag, ".err_word_count"}, err_word_count, exp_ewc);
    chk({tag, ".err_bit_count"}, err_bit_count, exp_ebc);
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    din_valid = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_wc = 0; exp_ewc = 0; exp_ebc = 0;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.locked", locked, 0);
    chk("reset.err_flag", err_flag, 0);
    stats("reset");
    @(negedge clk);
    rst = 1'b0;

    // clean stream from seed 0x01: lock after the 5th word
    g = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, g);
      g = nxt(g);
      chk($sformatf("acquire%0d.locked", i), locked, (i < 4) ? 0 : 1);
    end
    chk("acquire.last_word", g, 8'h08);
    stats("acquire");

    // locked clean words are counted
    for (int i = 0; i < 3; i++) begin
      step(1'b1, g);
      g = nxt(g);
      exp_wc++;
      chk("clean.err_flag", err_flag, 0);
    end
    stats("clean");

    // single 2-bit error
    step(1'b1, g ^ 8'h03);
    g = nxt(g);
    exp_wc++; exp_ewc++; exp_ebc += 2;
    chk("err1.err_flag", err_flag, 1);
    chk("err1.locked", locked, 1);
    stats("err1");
    step(1'b1, g);
    g = nxt(g);
    exp_wc++;
    chk("after_err.err_flag", err_flag, 0);
    stats("after_err");

    // four inverted words force unlock
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ~g);
      g = nxt(g);
      exp_wc++; exp_ewc++; exp_ebc += 8;
      chk($sformatf("inv%0d.err_flag", i), err_flag, 1);
      chk($sformatf("inv%0d.locked", i), locked, (i < 3) ? 1 : 0);
    end
    stats("inv");
    chk("inv.ebc_total", err_bit_count, 34);

    // re-lock after 5 clean words, statistics retained
    for (int i = 0; i < 5; i++) begin
      step(1'b1, g);
      g = nxt(g);
      chk($sformatf("relock%0d.locked", i), locked, (i < 4) ? 0 : 1);
    end
    stats("relock");

    // idle cycles carry garbage and must change nothing
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hAA);
      chk("idle.err_flag", err_flag, 0);
    end
    stats("idle");
    for (int i = 0; i < 2; i++) begin
      step(1'b1, g);
      g = nxt(g);
      exp_wc++;
    end
    chk("post_idle.err_flag", err_flag, 0);
    stats("post_idle");

    // clear together with an errored word
    clear = 1'b1;
    step(1'b1, g ^ 8'h80);
    clear = 1'b0;
    g = nxt(g);
    exp_wc = 0; exp_ewc = 0; exp_ebc = 0;
    chk("clear.err_flag", err_flag, 1);
    chk("clear.locked", locked, 1);
    stats("clear");
    step(1'b1, g);
    g = nxt(g);
    exp_wc = 1;
    stats("after_clear");

    // asynchronous reset mid-lock, checked before any clock edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_wc = 0;
    chk("async_rst.locked", locked, 0);
    stats("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // all-zero stream never locks
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h00);
      chk("zeros.locked", locked, 0);
    end
    stats("zeros");

    // valid toggling every cycle on a clean stream
    g = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, g);
      g = nxt(g);
      step(1'b0, 8'h55);
      chk($sformatf("toggle%0d.locked", i), locked, (i < 4) ? 0 : 1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, g);
      g = nxt(g);
      exp_wc++;
      step(1'b0, 8'hFF);
      chk("toggle_locked.err_flag", err_flag, 0);
    end
    stats("toggle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
